// File: rtl/vga_text_pkg.sv
// Shared constants for the text console: FSM encodings, control codes, screen geometry.
package vga_text_pkg;

  localparam int unsigned DEF_COLS = 80;
  localparam int unsigned DEF_ROWS = 30;

  typedef logic [2:0] state_t;

  localparam state_t IDLE      = 3'd0;
  localparam state_t PUT       = 3'd1;
  localparam state_t PUT_BS    = 3'd2;
  localparam state_t NL        = 3'd3;
  localparam state_t SCROLL_RD = 3'd4;
  localparam state_t SCROLL_WR = 3'd5;
  localparam state_t FILL      = 3'd6;
  localparam state_t CLEAR     = 3'd7;

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_FF = 8'h0C;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/vga_text_console.sv
// Character-stream controller owning the single port of the text buffer.
// Places printable bytes at the cursor, handles LF/CR/BS/FF, and runs scroll
// and clear as read/write bursts.
module vga_text_console
  import vga_text_pkg::*;
#(
  parameter int unsigned COLS   = DEF_COLS,
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter int unsigned ADDR_W = 16,
  parameter logic [7:0]  BLANK  = 8'h20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_char,
  output logic              busy,
  output logic [6:0]        cursor_col,
  output logic [4:0]        cursor_row,
  output logic              buf_we,
  output logic              buf_re,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [7:0]        buf_wdata,
  input  logic [7:0]        buf_rdata
);

  localparam logic [ADDR_W-1:0] COLS_A        = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_CELL     = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'(COLS * (ROWS - 1));
  localparam logic [6:0]        LAST_COL      = 7'(COLS - 1);
  localparam logic [4:0]        LAST_ROW      = 5'(ROWS - 1);

  state_t            state_q, state_d;
  logic [6:0]        col_q, col_d;
  logic [4:0]        row_q, row_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;  // always cursor_row * COLS
  logic [ADDR_W-1:0] ptr_q, ptr_d;            // burst pointer: scroll src, fill dst, clear addr
  logic [7:0]        char_q, char_d;
  logic [ADDR_W-1:0] addr_hold_q;
  logic [7:0]        wdata_hold_q;

  logic              we, re, newline;
  logic [ADDR_W-1:0] addr_now, cursor_addr;
  logic [7:0]        wdata_now;

  assign cursor_addr = row_base_q + ADDR_W'(col_q);

  // Next-state, cursor and burst sequencing; address/data hold when port is idle.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    ptr_d      = ptr_q;
    char_d     = char_q;
    we         = 1'b0;
    re         = 1'b0;
    newline    = 1'b0;
    addr_now   = addr_hold_q;
    wdata_now  = wdata_hold_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (is_printable(in_char)) begin
            char_d  = in_char;
            state_d = PUT;
          end else if (in_char == CH_LF) begin
            state_d = NL;
          end else if (in_char == CH_CR) begin
            col_d = '0;
          end else if (in_char == CH_BS) begin
            if (col_q != '0) begin
              col_d   = col_q - 7'd1;
              state_d = PUT_BS;
            end
          end else if (in_char == CH_FF) begin
            ptr_d   = '0;
            state_d = CLEAR;
          end
        end
      end
      PUT: begin
        we        = 1'b1;
        addr_now  = cursor_addr;
        wdata_now = char_q;
        if (col_q != LAST_COL) begin
          col_d   = col_q + 7'd1;
          state_d = IDLE;
        end else begin
          newline = 1'b1;
        end
      end
      PUT_BS: begin
        we        = 1'b1;
        addr_now  = cursor_addr;
        wdata_now = BLANK;
        state_d   = IDLE;
      end
      NL: newline = 1'b1;
      SCROLL_RD: begin
        re       = 1'b1;
        addr_now = ptr_q;
        state_d  = SCROLL_WR;
      end
      SCROLL_WR: begin
        we        = 1'b1;
        addr_now  = ptr_q - COLS_A;
        wdata_now = buf_rdata;
        ptr_d     = ptr_q + 1'b1;
        if (ptr_q == LAST_CELL) begin
          ptr_d   = LAST_ROW_BASE;
          state_d = FILL;
        end else begin
          state_d = SCROLL_RD;
        end
      end
      FILL: begin
        we        = 1'b1;
        addr_now  = ptr_q;
        wdata_now = BLANK;
        ptr_d     = ptr_q + 1'b1;
        if (ptr_q == LAST_CELL) state_d = IDLE;
      end
      CLEAR: begin
        we        = 1'b1;
        addr_now  = ptr_q;
        wdata_now = BLANK;
        ptr_d     = ptr_q + 1'b1;
        if (ptr_q == LAST_CELL) begin
          col_d      = '0;
          row_d      = '0;
          row_base_d = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Shared by LF and by a printable landing in the last column.
    if (newline) begin
      col_d = '0;
      if (row_q != LAST_ROW) begin
        row_d      = row_q + 5'd1;
        row_base_d = row_base_q + COLS_A;
        state_d    = IDLE;
      end else begin
        ptr_d   = COLS_A;
        state_d = SCROLL_RD;
      end
    end
  end

  // State registers; synchronous reset aborts any burst immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      row_base_q   <= '0;
      ptr_q        <= '0;
      char_q       <= '0;
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      row_base_q   <= row_base_d;
      ptr_q        <= ptr_d;
      char_q       <= char_d;
      addr_hold_q  <= addr_now;
      wdata_hold_q <= wdata_now;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign cursor_col = col_q;
  assign cursor_row = row_q;
  assign buf_we     = we;
  assign buf_re     = re;
  assign buf_addr   = addr_now;
  assign buf_wdata  = wdata_now;

endmodule

// File: doc/vga_text_console.md
Name: vga_text_console

Overview:
- Character-stream controller that owns the single write/read port of the 80x30 character buffer used by the text-mode VGA display.
- Accepts ASCII bytes from the CPU-side bus logic over a valid/ready handshake.
- Places each byte at the cursor, interprets control codes, and sequences multi-cycle operations (scroll, clear) as buffer read/write bursts.
- Firmware never computes buffer addresses.

Parameters:
- COLS, 80, characters per row.
- ROWS, 30, rows per screen.
- ADDR_W, 16, buffer address width.
- BLANK, 8'h20, fill character for clear and scroll.

Ports:
- clk  in  1  system clock, same domain as buffer write port
- reset  in  1  synchronous, active-high
- in_valid  in  1  in_char valid
- in_ready  out  1  console can accept a byte this cycle
- in_char  in  8  ASCII byte
- busy  out  1  high whenever state != IDLE
- cursor_col  out  7  current column, 0..COLS-1
- cursor_row  out  5  current row, 0..ROWS-1
- buf_we  out  1  buffer write strobe
- buf_re  out  1  buffer read strobe
- buf_addr  out  ADDR_W  buffer address, row*COLS+col
- buf_wdata  out  8  write data
- buf_rdata  in  8  read data, valid the cycle after buf_re

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - state IDLE, cursor 0/0, row_base 0.
  - buf_we 0, buf_re 0, buf_addr 0, buf_wdata 0.
  - in_ready 1 (first cycle after reset), busy 0.
  - Buffer contents are not touched by reset.
- Reset mid-operation: abort immediately. No buf_we/buf_re in the cycle after reset is sampled high.
- Handshake:
  - Byte accepted on clk edge where in_valid && in_ready.
  - in_ready = (state == IDLE).
  - in_char sampled only on acceptance.
- Address arithmetic:
  - row_base register tracks cursor_row*COLS; it is incremented or reset, never multiplied.
  - buf_addr = row_base + cursor_col, truncated to ADDR_W.
- State IDLE: on accept, decode in_char.
  - 0x20..0x7E -> PUT.
  - 0x0A (LF) -> NL.
  - 0x0D (CR) -> col = 0, stay IDLE.
  - 0x08 (BS) -> if col > 0 then col -= 1, go PUT_BS; else ignored.
  - 0x0C (FF) -> CLEAR.
  - Any other byte is consumed with no effect.
- PUT (1 cycle): buf_we=1, addr=cursor, wdata=char.
  - If col < COLS-1: col += 1, go IDLE.
  - Else col = 0 and NL semantics apply.
  - Throughput: one printable per 2 cycles.
- PUT_BS (1 cycle): buf_we=1, wdata=BLANK at the new cursor position; cursor unchanged; go IDLE.
- NL (1 cycle, no buffer access):
  - If row < ROWS-1: row += 1, row_base += COLS, go IDLE.
  - Else: row stays ROWS-1, go SCROLL_RD with src = COLS.
- SCROLL_RD: buf_re=1, addr=src; go SCROLL_WR.
- SCROLL_WR: buf_we=1, addr=src-COLS, wdata=buf_rdata, src += 1.
  - If src was COLS*ROWS-1, go FILL with dst = COLS*(ROWS-1).
  - Else go SCROLL_RD.
  - Cost: 2 cycles per cell, (ROWS-1)*COLS cells = 4640 cycles.
- FILL: buf_we=1, addr=dst, wdata=BLANK, dst += 1.
  - After dst = COLS*ROWS-1, go IDLE.
  - Cost: 80 cycles.
- CLEAR: buf_we=1, wdata=BLANK, addr 0..COLS*ROWS-1, one cell per cycle (2400 cycles). Then cursor 0/0, row_base 0, go IDLE.
- Port exclusivity: buf_we and buf_re are never high in the same cycle.
- Quiet port: buf_addr and buf_wdata hold their last value when no strobe is active.
- Ignored input: in_valid while busy has no effect; the byte stays pending on the upstream side.

Decomposition:
- Package vga_text_pkg:
  - State enum: IDLE, PUT, PUT_BS, NL, SCROLL_RD, SCROLL_WR, FILL, CLEAR.
  - Control-code constants: CH_LF, CH_CR, CH_BS, CH_FF.
  - Default COLS/ROWS.
- No sub-module: cursor, row_base and burst counters are small and tightly coupled to the FSM. Implement as a single module.

Test Plan:
- Print: after reset send 'A','B' -> buf_we with addr 0 data 0x41, then addr 1 data 0x42; cursor 2/0; in_ready low exactly one cycle per byte.
- Line wrap: send 80 x 'x' then 'y' -> 'y' written at addr 80; cursor 1/1.
- Newline / CR / BS: send "ab", CR, 'c', LF, BS:
  - 'c' written at addr 0.
  - Cursor 0/1 after LF.
  - BS at col 0 ignored, no write.
  - Separately, "ab" then BS writes 0x20 at addr 1; cursor 1/0.
- Scroll: preload model buffer with row r = char 0x30+r; put cursor on row 29, send LF:
  - busy for 4640+80+1 cycles.
  - Model buffer rows 0..28 = 0x31..0x4D.
  - Row 29 = 0x20.
  - Cursor 0/29.
  - No write to an address >= 2400.
- Clear: send FF -> 2400 writes of 0x20 at addrs 0..2399 in consecutive cycles; cursor 0/0; in_ready returns high on the following cycle.
- Reset mid-scroll: assert reset 100 cycles into a scroll -> next cycle buf_we=buf_re=0, cursor 0/0, in_ready=1; a subsequent 'Z' is written at addr 0.
